// File: rtl/gomoku_board_ctrl_if.sv
// Button, read-port and status bundle between the Gomoku UI front end and the board engine.
// The master side drives buttons and read addresses; the slave side is the engine.
interface gomoku_board_ctrl_if;
    logic       new_game;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_place;
    logic [3:0] rd_row;
    logic [3:0] rd_col;
    logic [1:0] rd_stone;
    logic [3:0] cursor_row;
    logic [3:0] cursor_col;
    logic [1:0] turn;
    logic       busy;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output new_game, btn_up, btn_down, btn_left, btn_right, btn_place,
        output rd_row, rd_col,
        input  rd_stone, cursor_row, cursor_col, turn, busy, game_over, winner
    );

    modport slave (
        input  new_game, btn_up, btn_down, btn_left, btn_right, btn_place,
        input  rd_row, rd_col,
        output rd_stone, cursor_row, cursor_col, turn, busy, game_over, winner
    );
endinterface

// File: rtl/gomoku_board_ctrl.sv
// Gomoku game-state engine: N x N board, cursor, alternating placement and a
// sequential five-in-a-row scan after each stone.
//   state        | meaning
//   ST_IDLE      | accepting cursor moves and placements
//   ST_PROBE_POS | walking origin + k*d[dir], one cell per cycle
//   ST_PROBE_NEG | walking origin - k*d[dir], then next direction or resolve
//   ST_RESOLVE   | apply win / draw / turn change, back to idle
module gomoku_board_ctrl #(
    parameter int N       = 15,
    parameter int WIN_LEN = 5
) (
    input  logic               clk,
    input  logic               rst,
    gomoku_board_ctrl_if.slave bus
);
    localparam int CELLS = N * N;
    localparam int IW    = $clog2(CELLS);
    localparam int SW    = $clog2(CELLS + 1);

    localparam logic [3:0]        CENTER  = 4'(N / 2);
    localparam logic [3:0]        LAST    = 4'(N - 1);
    localparam logic [4:0]        N_U     = 5'(N);
    localparam logic signed [6:0] N_S     = 7'(N);
    localparam logic [3:0]        K_LAST  = 4'(WIN_LEN - 1);
    localparam logic [4:0]        WIN_CNT = 5'(WIN_LEN);
    localparam logic [SW-1:0]     FULL    = SW'(CELLS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROBE_POS,
        ST_PROBE_NEG,
        ST_RESOLVE
    } state_t;

    state_t        state_q;
    logic [1:0]    board_q [CELLS];
    logic [3:0]    cur_row_q, cur_col_q;
    logic [3:0]    cur_row_d, cur_col_d;
    logic [1:0]    turn_q;
    logic [1:0]    winner_q;
    logic [1:0]    rd_stone_q;
    logic          busy_q;
    logic          game_over_q;
    logic [3:0]    org_row_q, org_col_q;
    logic [1:0]    org_color_q;
    logic [1:0]    dir_q;
    logic [3:0]    k_q;
    logic [4:0]    count_q;
    logic          win_q;
    logic [SW-1:0] stones_q;

    logic signed [6:0] dr, dc, pr, pc;
    logic              probe_in, probe_hit, probe_more;
    logic [IW-1:0]     probe_idx, cur_idx, rd_idx;
    logic              rd_in;
    logic [4:0]        count_hit;
    logic              move_ok, place_ok;

    // Probe address: origin plus or minus k steps along the current direction.
    always_comb begin
        dr = 7'sd1;
        dc = 7'sd0;
        case (dir_q)
            2'd0:    begin dr = 7'sd0; dc = 7'sd1;  end
            2'd1:    begin dr = 7'sd1; dc = 7'sd0;  end
            2'd2:    begin dr = 7'sd1; dc = 7'sd1;  end
            default: begin dr = 7'sd1; dc = -7'sd1; end
        endcase
        if (state_q == ST_PROBE_NEG) begin
            dr = -dr;
            dc = -dc;
        end
        pr = $signed({3'b000, org_row_q}) + dr * $signed({3'b000, k_q});
        pc = $signed({3'b000, org_col_q}) + dc * $signed({3'b000, k_q});
        probe_in  = !pr[6] && (pr < N_S) && !pc[6] && (pc < N_S);
        probe_idx = probe_in ? (IW'(pr[3:0]) * IW'(N) + IW'(pc[3:0])) : '0;
        probe_hit = probe_in && (board_q[probe_idx] == org_color_q);
        probe_more = probe_hit && (k_q < K_LAST);
        count_hit  = count_q + {4'd0, probe_hit};
    end

    always_comb begin
        cur_idx  = IW'(cur_row_q) * IW'(N) + IW'(cur_col_q);
        rd_in    = ({1'b0, bus.rd_row} < N_U) && ({1'b0, bus.rd_col} < N_U);
        rd_idx   = rd_in ? (IW'(bus.rd_row) * IW'(N) + IW'(bus.rd_col)) : '0;
        move_ok  = (state_q == ST_IDLE) && !game_over_q && !bus.new_game;
        place_ok = move_ok && bus.btn_place && (board_q[cur_idx] == 2'd0);
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        if (move_ok) begin
            if (bus.btn_up && !bus.btn_down && (cur_row_q != 4'd0))
                cur_row_d = cur_row_q - 4'd1;
            else if (bus.btn_down && !bus.btn_up && (cur_row_q != LAST))
                cur_row_d = cur_row_q + 4'd1;
            if (bus.btn_left && !bus.btn_right && (cur_col_q != 4'd0))
                cur_col_d = cur_col_q - 4'd1;
            else if (bus.btn_right && !bus.btn_left && (cur_col_q != LAST))
                cur_col_d = cur_col_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < CELLS; i++) board_q[i] <= 2'd0;
            cur_row_q   <= CENTER;
            cur_col_q   <= CENTER;
            turn_q      <= 2'd1;
            winner_q    <= 2'd0;
            rd_stone_q  <= 2'd0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
            org_row_q   <= 4'd0;
            org_col_q   <= 4'd0;
            org_color_q <= 2'd0;
            dir_q       <= 2'd0;
            k_q         <= 4'd1;
            count_q     <= 5'd1;
            win_q       <= 1'b0;
            stones_q    <= '0;
        end else begin
            rd_stone_q <= rd_in ? board_q[rd_idx] : 2'd0;
            if (bus.new_game) begin
                state_q     <= ST_IDLE;
                for (int i = 0; i < CELLS; i++) board_q[i] <= 2'd0;
                cur_row_q   <= CENTER;
                cur_col_q   <= CENTER;
                turn_q      <= 2'd1;
                winner_q    <= 2'd0;
                busy_q      <= 1'b0;
                game_over_q <= 1'b0;
                win_q       <= 1'b0;
                stones_q    <= '0;
            end else begin
                cur_row_q <= cur_row_d;
                cur_col_q <= cur_col_d;
                unique case (state_q)
                    ST_IDLE: begin
                        if (place_ok) begin
                            board_q[cur_idx] <= turn_q;
                            stones_q    <= stones_q + SW'(1);
                            org_row_q   <= cur_row_q;
                            org_col_q   <= cur_col_q;
                            org_color_q <= turn_q;
                            dir_q       <= 2'd0;
                            k_q         <= 4'd1;
                            count_q     <= 5'd1;
                            win_q       <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= ST_PROBE_POS;
                        end
                    end
                    ST_PROBE_POS: begin
                        count_q <= count_hit;
                        if (probe_more) begin
                            k_q <= k_q + 4'd1;
                        end else begin
                            k_q     <= 4'd1;
                            state_q <= ST_PROBE_NEG;
                        end
                    end
                    ST_PROBE_NEG: begin
                        if (probe_more) begin
                            count_q <= count_hit;
                            k_q     <= k_q + 4'd1;
                        end else if (count_hit >= WIN_CNT) begin
                            win_q   <= 1'b1;
                            state_q <= ST_RESOLVE;
                        end else if (dir_q != 2'd3) begin
                            dir_q   <= dir_q + 2'd1;
                            k_q     <= 4'd1;
                            count_q <= 5'd1;
                            state_q <= ST_PROBE_POS;
                        end else begin
                            state_q <= ST_RESOLVE;
                        end
                    end
                    ST_RESOLVE: begin
                        if (win_q) begin
                            game_over_q <= 1'b1;
                            winner_q    <= org_color_q;
                        end else if (stones_q == FULL) begin
                            game_over_q <= 1'b1;
                            winner_q    <= 2'd0;
                        end else begin
                            turn_q <= (turn_q == 2'd1) ? 2'd2 : 2'd1;
                        end
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.rd_stone   = rd_stone_q;
    assign bus.cursor_row = cur_row_q;
    assign bus.cursor_col = cur_col_q;
    assign bus.turn       = turn_q;
    assign bus.busy       = busy_q;
    assign bus.game_over  = game_over_q;
    assign bus.winner     = winner_q;
endmodule

// File: tb/tb_gomoku_board_ctrl.sv
// Directed bench for gomoku_board_ctrl (N=15, WIN_LEN=5): cursor clamping,
// placement, read latency, row/anti-diagonal wins, near-miss, draw fill, new_game and reset.
module tb_gomoku_board_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gomoku_board_ctrl_if bus ();

    gomoku_board_ctrl #(.N(15), .WIN_LEN(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_btns();
        bus.new_game  = 1'b0;
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        bus.btn_place = 1'b0;
    endtask

    // One-cycle pulse of any combination of buttons: {new_game, up, down, left, right, place}
    task automatic pulse(input logic [5:0] b);
        {bus.new_game, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right, bus.btn_place} = b;
        step();
        clear_btns();
    endtask

    localparam logic [5:0] B_NEW = 6'b100000, B_UP = 6'b010000, B_DN = 6'b001000;
    localparam logic [5:0] B_LT  = 6'b000100, B_RT = 6'b000010, B_PL = 6'b000001;

    task automatic move_to(input int r, input int c);
        int n;
        n = 0;
        while (((bus.cursor_row != 4'(r)) || (bus.cursor_col != 4'(c))) && (n < 40)) begin
            bus.btn_up    = (bus.cursor_row > r);
            bus.btn_down  = (bus.cursor_row < r);
            bus.btn_left  = (bus.cursor_col > c);
            bus.btn_right = (bus.cursor_col < c);
            step();
            clear_btns();
            n++;
        end
        chk("move_to row", bus.cursor_row, r);
        chk("move_to col", bus.cursor_col, c);
    endtask

    // Counts sampled cycles with busy high, continuing from n0.
    task automatic wait_idle(input int n0, output int n);
        n = n0;
        while (bus.busy && (n < 60)) begin
            n++;
            step();
        end
        if (n >= 60) chk("busy bound expired", n, 0);
    endtask

    task automatic place_at(input int r, input int c, output int n);
        move_to(r, c);
        pulse(B_PL);
        wait_idle(0, n);
    endtask

    task automatic rd(input int r, input int c, output logic [1:0] v);
        bus.rd_row = 4'(r);
        bus.rd_col = 4'(c);
        step();
        v = bus.rd_stone;
    endtask

    int         n;
    logic [1:0] v;
    int         br[113], bc[113], wr[112], wc[112];
    int         nb, nw;

    initial begin
        clear_btns();
        bus.rd_row = 4'd0;
        bus.rd_col = 4'd0;
        step();
        step();
        chk("reset cursor_row", bus.cursor_row, 7);
        chk("reset cursor_col", bus.cursor_col, 7);
        chk("reset turn", bus.turn, 1);
        chk("reset busy", bus.busy, 0);
        chk("reset game_over", bus.game_over, 0);
        chk("reset winner", bus.winner, 0);
        chk("reset rd_stone", bus.rd_stone, 0);
        rst = 1'b1;
        step();

        // Cursor movement and clamping
        pulse(B_RT);
        chk("right once", bus.cursor_col, 8);
        repeat (9) pulse(B_RT);
        chk("right clamp col", bus.cursor_col, 14);
        chk("right keeps row", bus.cursor_row, 7);
        repeat (20) pulse(B_UP);
        chk("up clamp row", bus.cursor_row, 0);
        pulse(B_UP | B_DN);
        chk("up+down cancel", bus.cursor_row, 0);
        pulse(B_LT | B_RT);
        chk("left+right cancel", bus.cursor_col, 14);
        pulse(B_DN | B_LT);
        chk("diag move row", bus.cursor_row, 1);
        chk("diag move col", bus.cursor_col, 13);

        // First placement with read latency and lone-stone scan length
        move_to(7, 7);
        rd(7, 7, v);
        chk("rd empty", v, 0);
        bus.btn_place = 1'b1;
        step();
        clear_btns();
        chk("busy after place", bus.busy, 1);
        chk("turn held during check", bus.turn, 1);
        chk("rd before visible", bus.rd_stone, 0);
        step();
        chk("rd after latency", bus.rd_stone, 1);
        wait_idle(1, n);
        chk("lone stone busy cycles", n, 9);
        chk("turn after black", bus.turn, 2);
        pulse(B_PL);
        chk("occupied place busy", bus.busy, 0);
        step();
        chk("occupied place busy later", bus.busy, 0);
        chk("occupied place turn", bus.turn, 2);

        // Black row win completed in the middle
        place_at(8, 0, n);
        place_at(3, 3, n);
        place_at(12, 0, n);
        place_at(3, 4, n);
        place_at(12, 2, n);
        place_at(3, 6, n);
        place_at(12, 4, n);
        place_at(3, 7, n);
        place_at(12, 6, n);
        chk("turn before win", bus.turn, 1);
        chk("no early game_over", bus.game_over, 0);
        move_to(3, 5);
        pulse(B_PL | B_DN);
        chk("place+move busy", bus.busy, 1);
        chk("place+move row", bus.cursor_row, 4);
        chk("place+move col", bus.cursor_col, 5);
        wait_idle(0, n);
        chk("row win busy cycles", n, 7);
        chk("row win game_over", bus.game_over, 1);
        chk("row win winner", bus.winner, 1);
        chk("row win turn", bus.turn, 1);
        rd(3, 5, v);
        chk("rd stone at pre-move cursor", v, 1);
        rd(8, 0, v);
        chk("rd white stone", v, 2);
        rd(7, 15, v);
        chk("rd col out of range", v, 0);
        rd(15, 0, v);
        chk("rd row out of range", v, 0);
        pulse(B_RT);
        chk("move after game_over", bus.cursor_col, 5);
        pulse(B_PL);
        chk("place after game_over busy", bus.busy, 0);
        rd(4, 5, v);
        chk("place after game_over cell", v, 0);

        // Anti-diagonal white win at the board edge
        pulse(B_NEW);
        chk("new_game cursor_row", bus.cursor_row, 7);
        chk("new_game cursor_col", bus.cursor_col, 7);
        chk("new_game turn", bus.turn, 1);
        chk("new_game game_over", bus.game_over, 0);
        chk("new_game winner", bus.winner, 0);
        rd(3, 5, v);
        chk("new_game board clear", v, 0);
        place_at(14, 0, n);
        place_at(1, 13, n);
        place_at(14, 2, n);
        place_at(2, 12, n);
        place_at(14, 4, n);
        place_at(3, 11, n);
        place_at(14, 6, n);
        place_at(4, 10, n);
        place_at(14, 8, n);
        chk("turn before white win", bus.turn, 2);
        place_at(0, 14, n);
        chk("anti-diag busy cycles", n, 12);
        chk("anti-diag game_over", bus.game_over, 1);
        chk("anti-diag winner", bus.winner, 2);

        // Four in a row is not a win
        pulse(B_NEW);
        place_at(10, 0, n);
        place_at(0, 0, n);
        place_at(10, 1, n);
        place_at(0, 2, n);
        place_at(10, 2, n);
        place_at(0, 4, n);
        place_at(10, 3, n);
        chk("four busy cycles", n, 12);
        chk("four game_over", bus.game_over, 0);
        chk("four winner", bus.winner, 0);
        chk("four turn toggles", bus.turn, 2);

        // new_game during a check
        move_to(5, 5);
        pulse(B_PL);
        chk("mid-check busy", bus.busy, 1);
        pulse(B_NEW);
        chk("abort busy", bus.busy, 0);
        chk("abort cursor_row", bus.cursor_row, 7);
        chk("abort cursor_col", bus.cursor_col, 7);
        chk("abort turn", bus.turn, 1);
        chk("abort game_over", bus.game_over, 0);
        rd(10, 0, v);
        chk("abort board clear", v, 0);
        rd(5, 5, v);
        chk("abort new stone cleared", v, 0);
        chk("abort stays idle", bus.busy, 0);

        // Pulses coincident with new_game are ignored
        pulse(B_NEW | B_RT | B_PL);
        chk("coincident cursor_col", bus.cursor_col, 7);
        chk("coincident busy", bus.busy, 0);
        rd(7, 7, v);
        chk("coincident no stone", v, 0);

        // Async reset during a check
        place_at(7, 7, n);
        chk("turn before reset", bus.turn, 2);
        move_to(2, 2);
        bus.rd_row = 4'd2;
        bus.rd_col = 4'd2;
        pulse(B_PL);
        step();
        chk("pre-reset rd_stone", bus.rd_stone, 2);
        chk("pre-reset busy", bus.busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst rd_stone", bus.rd_stone, 0);
        chk("async rst busy", bus.busy, 0);
        chk("async rst turn", bus.turn, 1);
        chk("async rst cursor_row", bus.cursor_row, 7);
        chk("async rst cursor_col", bus.cursor_col, 7);
        chk("async rst game_over", bus.game_over, 0);
        chk("async rst winner", bus.winner, 0);
        #2;
        rst = 1'b1;
        rd(7, 7, v);
        chk("async rst board clear", v, 0);

        // Full-board draw: colour from bit 1 of (col + 2*row) keeps every run at most 2
        nb = 0;
        nw = 0;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 15; c++) begin
                if ((((c + 2 * r) >> 1) & 1) == 0) begin
                    br[nb] = r; bc[nb] = c; nb++;
                end else begin
                    wr[nw] = r; wc[nw] = c; nw++;
                end
            end
        end
        for (int i = 0; i < 112; i++) begin
            place_at(br[i], bc[i], n);
            place_at(wr[i], wc[i], n);
        end
        chk("fill turn before last", bus.turn, 1);
        chk("fill no early game_over", bus.game_over, 0);
        place_at(br[112], bc[112], n);
        chk("draw game_over", bus.game_over, 1);
        chk("draw winner", bus.winner, 0);
        chk("draw turn held", bus.turn, 1);
        chk("draw busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
